// File: rtl/psum_accumulator.sv
// Lane-wise saturating accumulator for PE-mesh partial-sum rows. Rows are summed
// into an E-entry buffer over a configured number of passes, then drained in order.
module psum_accumulator #(
    parameter int depth = 2,
    parameter int D     = 1 << depth,
    parameter int W     = 16,
    parameter int L     = 3,
    parameter int E     = 1 << L
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           start,
    input  logic [7:0]     cfgPasses,
    input  logic [L:0]     cfgLen,
    input  logic [W*D-1:0] psIn,
    input  logic           psValid,
    output logic           psReady,
    output logic [W*D-1:0] outData,
    output logic           outValid,
    input  logic           outReady,
    output logic           busy,
    output logic           done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t         state_q;
    logic [L-1:0]   rp_q;
    logic [7:0]     pc_q;
    logic [7:0]     passes_q;
    logic [L:0]     len_q;
    logic [W*D-1:0] out_data_q;
    logic           out_valid_q;
    logic           done_q;

    // Reset-less row storage: the first pass of every job overwrites what it uses.
    logic [W*D-1:0] acc_q [E];

    logic [7:0]     cfg_passes_n;
    logic [L:0]     cfg_len_n;
    logic [W*D-1:0] rd_row;
    logic [W*D-1:0] wr_row;
    logic           ps_accept;
    logic           out_fire;
    logic           last_row;
    logic           last_pass;

    function automatic logic [W-1:0] sat_add(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        s = {a[W-1], a} + {b[W-1], b};
        if (s[W] != s[W-1]) begin
            sat_add = s[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end else begin
            sat_add = s[W-1:0];
        end
    endfunction

    always_comb begin
        cfg_passes_n = (cfgPasses == 8'd0) ? 8'd1 : cfgPasses;
        cfg_len_n    = ((cfgLen == '0) || (cfgLen > (L+1)'(E))) ? (L+1)'(E) : cfgLen;
    end

    assign psReady   = (state_q == S_ACCUM);
    assign busy      = (state_q != S_IDLE);
    assign outData   = out_data_q;
    assign outValid  = out_valid_q;
    assign done      = done_q;

    assign ps_accept = psValid && psReady;
    assign out_fire  = out_valid_q && outReady;
    // len_q == E truncates to zero, so the subtraction wraps to E-1 as intended.
    assign last_row  = (rp_q == L'(len_q - 1'b1));
    assign last_pass = (pc_q == (passes_q - 8'd1));
    assign rd_row    = acc_q[rp_q];

    always_comb begin
        wr_row = '0;
        for (int i = 0; i < D; i++) begin
            if (pc_q == 8'd0) begin
                wr_row[i*W +: W] = psIn[i*W +: W];
            end else begin
                wr_row[i*W +: W] = sat_add(rd_row[i*W +: W], psIn[i*W +: W]);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (ps_accept) begin
            acc_q[rp_q] <= wr_row;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            rp_q        <= '0;
            pc_q        <= 8'd0;
            passes_q    <= 8'd1;
            len_q       <= (L+1)'(E);
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q  <= S_ACCUM;
                        rp_q     <= '0;
                        pc_q     <= 8'd0;
                        passes_q <= cfg_passes_n;
                        len_q    <= cfg_len_n;
                    end
                end
                S_ACCUM: begin
                    if (ps_accept) begin
                        if (last_row) begin
                            rp_q <= '0;
                            pc_q <= pc_q + 8'd1;
                            if (last_pass) begin
                                state_q     <= S_DRAIN;
                                out_valid_q <= 1'b1;
                                // Row 0 may be the row being written right now (len=1).
                                out_data_q  <= (rp_q == '0) ? wr_row : acc_q[0];
                            end
                        end else begin
                            rp_q <= rp_q + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (out_fire) begin
                        if (last_row) begin
                            state_q     <= S_IDLE;
                            rp_q        <= '0;
                            out_valid_q <= 1'b0;
                            done_q      <= 1'b1;
                        end else begin
                            rp_q       <= rp_q + 1'b1;
                            out_data_q <= acc_q[rp_q + 1'b1];
                        end
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
